data_axi_bridge: RTL and testbench

- Converts the data-side SRAM-like request interface (req/addr_ok/data_ok) driven by the memory-access stage into a single-beat AXI4 master.
- Sits directly downstream of the memory-access stage, between it and the system AXI interconnect.
- Supports one outstanding transaction, which is either a read or a write.
- Generates write strobes from size and address, and returns registered read data with a one-cycle data_ok pulse.

---
 rtl/data_axi_bridge.sv | 167 ++++++++++++++++
 tb/tb_data_axi_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_axi_bridge.sv
// data_axi_bridge: data-side SRAM-like request port to single-beat AXI4 master.
// One outstanding read or write; byte strobes derived from size and address.
`default_nettype none

module data_axi_bridge #(
  parameter int ID_WIDTH = 4,
  parameter int RD_ID    = 0,
  parameter int WR_ID    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wdata,
  output logic [31:0]         data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic                bus_err,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [3:0]  strb_in;
  logic        aw_done, w_done;
  logic        aw_now, w_now;
  logic        accept;

  // Transaction ID, last flag and write-response ID carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast, bid};

  assign accept       = (state == IDLE) && data_req;
  assign data_addr_ok = accept;

  always_comb begin
    strb_in = 4'b1111;
    case (data_size)
      2'd0:    strb_in = 4'b0001 << data_addr[1:0];
      2'd1:    strb_in = data_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_in = 4'b1111;
    endcase
  end

  assign arid    = ID_WIDTH'(RD_ID);
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);

  assign awid    = ID_WIDTH'(WR_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};
  assign awburst = 2'b01;
  assign awvalid = (state == WR_REQ) && !aw_done;
  assign wvalid  = (state == WR_REQ) && !w_done;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid;
  assign bready  = (state == WR_RESP);

  assign aw_now = aw_done || (awvalid && awready);
  assign w_now  = w_done  || (wvalid && wready);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_req) state_nxt = data_wr ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready)  state_nxt = RD_DATA;
      RD_DATA: if (rvalid)   state_nxt = IDLE;
      WR_REQ:  if (aw_now && w_now) state_nxt = WR_RESP;
      WR_RESP: if (bvalid)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= 32'd0;
      size_q       <= 2'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      data_rdata   <= 32'd0;
      data_data_ok <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= data_addr;
        size_q  <= data_size;
        wdata_q <= data_wdata;
        wstrb_q <= strb_in;
      end
      // Completion flags live only while the write stays in WR_REQ.
      if (state == WR_REQ && state_nxt == WR_REQ) begin
        aw_done <= aw_now;
        w_done  <= w_now;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      data_data_ok <= 1'b0;
      bus_err      <= 1'b0;
      if (state == RD_DATA && rvalid) begin
        data_rdata   <= rdata;
        data_data_ok <= 1'b1;
        bus_err      <= (rresp != 2'b00);
      end else if (state == WR_RESP && bvalid) begin
        data_data_ok <= 1'b1;
        bus_err      <= (bresp != 2'b00);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_axi_bridge.sv
// Directed self-checking bench for data_axi_bridge.
`default_nettype none

module tb_data_axi_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok, bus_err;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  data_axi_bridge #(.ID_WIDTH(4), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 1; awready = 1; wready = 1; rvalid = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0; rid = 0; bid = 0; rlast = 1;
    tick(); tick();
    vecs++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_data_ok, bus_err, data_addr_ok} !== 8'h00) begin
      errs++; $display("FAIL reset_ctrl got %b exp 00000000",
        {arvalid, rready, awvalid, wvalid, bready, data_data_ok, bus_err, data_addr_ok});
    end
    vecs++;
    if (data_rdata !== 32'h0 || awaddr !== 32'h0 || wstrb !== 4'h0) begin
      errs++; $display("FAIL reset_regs got rdata=%h awaddr=%h wstrb=%h exp 0", data_rdata, awaddr, wstrb);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_word();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_1004;
    #1;
    vecs++;
    if (data_addr_ok !== 1'b1) begin errs++; $display("FAIL rd_addr_ok got %b exp 1", data_addr_ok); end
    tick(); data_req = 0; data_addr = 32'hFFFF_FFFF; data_size = 0;
    vecs++;
    if ({arvalid, araddr, arsize, arlen, arburst, arid} !== {1'b1, 32'h1004, 3'd2, 8'd0, 2'b01, 4'd0}) begin
      errs++; $display("FAIL rd_ar got v=%b a=%h s=%0d len=%0d b=%b id=%0d exp 1 1004 2 0 01 0",
        arvalid, araddr, arsize, arlen, arburst, arid);
    end
    tick();
    vecs++;
    if ({arvalid, rready} !== 2'b01) begin errs++; $display("FAIL rd_rready got %b exp 01", {arvalid, rready}); end
    rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
    tick(); rvalid = 0; rdata = 0;
    vecs++;
    if ({data_data_ok, bus_err, rready} !== 3'b100 || data_rdata !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL rd_done got ok/err/rready=%b rdata=%h exp 100 deadbeef",
        {data_data_ok, bus_err, rready}, data_rdata);
    end
    tick();
    vecs++;
    if (data_data_ok !== 1'b0 || data_rdata !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL rd_pulse got ok=%b rdata=%h exp 0 deadbeef", data_data_ok, data_rdata);
    end
  endtask

  task automatic test_write_strobes();
    logic [31:0] t_addr [4] = '{32'h2003, 32'h2002, 32'h2001, 32'h2000};
    logic [1:0]  t_size [4] = '{2'd0, 2'd1, 2'd0, 2'd3};
    logic [3:0]  t_strb [4] = '{4'b1000, 4'b1100, 4'b0010, 4'b1111};
    logic [2:0]  t_awsz [4] = '{3'd0, 3'd1, 3'd0, 3'd2};
    awready = 1; wready = 1;
    for (int i = 0; i < 4; i++) begin
      data_req = 1; data_wr = 1; data_size = t_size[i]; data_addr = t_addr[i];
      data_wdata = 32'h5A5A_5A5A ^ i;
      tick(); data_req = 0; data_wdata = 0; data_addr = 0;
      vecs++;
      if ({awvalid, wvalid, wlast, wstrb, awsize, awaddr, awid, awlen, awburst, wdata} !==
          {1'b1, 1'b1, 1'b1, t_strb[i], t_awsz[i], t_addr[i], 4'd1, 8'd0, 2'b01, 32'h5A5A_5A5A ^ i}) begin
        errs++; $display("FAIL wr_fields[%0d] got strb=%b awsize=%0d awaddr=%h wdata=%h v=%b%b%b exp strb=%b awsize=%0d",
          i, wstrb, awsize, awaddr, wdata, awvalid, wvalid, wlast, t_strb[i], t_awsz[i]);
      end
      tick();
      vecs++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
        errs++; $display("FAIL wr_bready[%0d] got %b exp 001", i, {awvalid, wvalid, bready});
      end
      bvalid = 1; bresp = 0;
      tick(); bvalid = 0;
      vecs++;
      if ({data_data_ok, bus_err, bready} !== 3'b100) begin
        errs++; $display("FAIL wr_done[%0d] got %b exp 100", i, {data_data_ok, bus_err, bready});
      end
    end
    tick();
  endtask

  task automatic test_aw_delay();
    awready = 0; wready = 1;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h3000; data_wdata = 32'h1234_5678;
    tick(); data_req = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) awready = 1;
      vecs++;
      if ({awvalid, wvalid, bready} !== {1'b1, (c == 1), 1'b0}) begin
        errs++; $display("FAIL awdly_cyc%0d got %b exp %b", c, {awvalid, wvalid, bready}, {1'b1, (c == 1), 1'b0});
      end
      tick();
    end
    vecs++;
    if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010) begin
      errs++; $display("FAIL awdly_bready got %b exp 0010", {awvalid, wvalid, bready, data_data_ok});
    end
    bvalid = 1;
    tick(); bvalid = 0;
    vecs++;
    if ({data_data_ok, bready} !== 2'b10) begin errs++; $display("FAIL awdly_ok got %b exp 10", {data_data_ok, bready}); end
    tick();
  endtask

  task automatic test_back_to_back();
    awready = 1; wready = 1;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h4000;
    tick(); data_req = 0;
    tick(); rvalid = 1; rdata = 32'hCAFE_F00D;
    tick(); rvalid = 0;
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h4002; data_wdata = 32'hABCD_ABCD;
    #1;
    vecs++;
    if ({data_data_ok, data_addr_ok} !== 2'b11 || data_rdata !== 32'hCAFE_F00D) begin
      errs++; $display("FAIL b2b_accept got ok/addr_ok=%b rdata=%h exp 11 cafef00d", {data_data_ok, data_addr_ok}, data_rdata);
    end
    tick(); data_req = 0;
    vecs++;
    if ({awvalid, wvalid, wstrb, awaddr} !== {1'b1, 1'b1, 4'b1100, 32'h4002} || data_data_ok !== 1'b0) begin
      errs++; $display("FAIL b2b_aw got v=%b%b strb=%b awaddr=%h ok=%b exp 11 1100 4002 0",
        awvalid, wvalid, wstrb, awaddr, data_data_ok);
    end
    tick(); bvalid = 1;
    tick(); bvalid = 0;
    vecs++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hCAFE_F00D) begin
      errs++; $display("FAIL b2b_wr_ok got ok=%b rdata=%h exp 1 cafef00d", data_data_ok, data_rdata);
    end
    tick();
  endtask

  task automatic test_slverr();
    data_req = 1; data_wr = 0; data_size = 0; data_addr = 32'h5001;
    tick(); data_req = 0;
    vecs++;
    if (arsize !== 3'd0) begin errs++; $display("FAIL err_arsize got %0d exp 0", arsize); end
    tick(); rvalid = 1; rdata = 32'h0000_7700; rresp = 2'b10;
    tick(); rvalid = 0; rresp = 0;
    vecs++;
    if ({data_data_ok, bus_err} !== 2'b11) begin errs++; $display("FAIL err_pulse got %b exp 11", {data_data_ok, bus_err}); end
    tick();
    vecs++;
    if ({data_data_ok, bus_err} !== 2'b00) begin errs++; $display("FAIL err_clear got %b exp 00", {data_data_ok, bus_err}); end
  endtask

  task automatic test_mid_reset();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h6000;
    tick(); data_req = 0;
    tick();
    vecs++;
    if (rready !== 1'b1) begin errs++; $display("FAIL mrst_rready_pre got %b exp 1", rready); end
    rst = 0; rvalid = 1; rdata = 32'h1111_2222;
    tick(); rvalid = 0;
    vecs++;
    if ({rready, data_data_ok, arvalid, bus_err} !== 4'b0000 || data_rdata !== 32'h0) begin
      errs++; $display("FAIL mrst_state got %b rdata=%h exp 0000 0", {rready, data_data_ok, arvalid, bus_err}, data_rdata);
    end
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vecs++;
      if ({data_data_ok, rready, arvalid} !== 3'b000) begin
        errs++; $display("FAIL mrst_after[%0d] got %b exp 000", c, {data_data_ok, rready, arvalid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_word();
    test_write_strobes();
    test_aw_delay();
    test_back_to_back();
    test_slverr();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

`default_nettype wire
